// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, IV, message-schedule sigma functions
// and the scheduler FSM encoding.
package sha256_pkg;

    localparam int LANES     = 4;
    localparam int UPD_DELAY = 4;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash value H0..H7, consumed by the core when clr_o is asserted.
    function automatic logic [31:0] sha256_iv(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'h6a09e667;
            3'd1:    v = 32'hbb67ae85;
            3'd2:    v = 32'h3c6ef372;
            3'd3:    v = 32'ha54ff53a;
            3'd4:    v = 32'h510e527f;
            3'd5:    v = 32'h9b05688c;
            3'd6:    v = 32'h1f83d9ab;
            default: v = 32'h5be0cd19;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_COMP,
        ST_UPD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant ROM: 6-bit round address in, K[addr] out one cycle later.
// Output reads zero whenever en_i is low so idle cycles present k=0.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [5:0]  addr_i,
    output logic [31:0] k_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_o <= '0;
        end else if (en_i) begin
            k_o <= K_TAB[addr_i];
        end else begin
            k_o <= '0;
        end
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler for 4 interleaved lanes: buffers a 64-word load and
// streams W[r]/K[r] round-robin per lane. Optional counter: SHA256_SCHED_BLK_CNT_EN.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        first_i,
    output logic        ready_o,
    output logic [31:0] w_o,
    output logic [31:0] k_o,
    output logic        clr_o,
    output logic        update_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] blk_cnt_o
);

    // Handshake: a word transfers on a rising edge where valid_i and ready_o are
    // both high; ready_o is registered and never depends on valid_i. Load index n
    // lands in msg_q[n[5:4]][n[3:0]] (lane-major, big-endian word order).

    // Last COMP count; counts past 255 present idle words before update_o starts.
    localparam logic [8:0] COMP_LAST = 9'(251 + UPD_DELAY);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [5:0]  ld_idx_q, ld_idx_d;
    logic        new_msg_q, new_msg_d;

    logic        ready_q;
    logic        clr_q;
    logic        upd_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] w_q;

    logic [31:0] msg_q [LANES][16];

    logic        xfer;
    logic [1:0]  lane;
    logic [5:0]  rnd;
    logic        word_act;
    logic        expand;
    logic [3:0]  idx_m16;
    logic [3:0]  idx_m15;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m2;
    logic [31:0] w_exp;
    logic [31:0] w_cur;

    assign xfer = valid_i & ready_q;

    // Each lane's 16-entry window holds W[r-16..r-1]; slot r mod 16 is W[r-16].
    always_comb begin
        lane     = cnt_q[1:0];
        rnd      = cnt_q[7:2];
        word_act = (state_q == ST_COMP) && !cnt_q[8];
        expand   = word_act && (rnd[5:4] != 2'b00);
        idx_m16  = rnd[3:0];
        idx_m15  = rnd[3:0] + 4'd1;
        idx_m7   = rnd[3:0] + 4'd9;
        idx_m2   = rnd[3:0] + 4'd14;
        w_exp    = sig1(msg_q[lane][idx_m2]) + msg_q[lane][idx_m7]
                 + sig0(msg_q[lane][idx_m15]) + msg_q[lane][idx_m16];
        w_cur    = (rnd[5:4] == 2'b00) ? msg_q[lane][idx_m16] : w_exp;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_idx_d  = ld_idx_q;
        new_msg_d = new_msg_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_LOAD;
                    ld_idx_d  = 6'd1;
                    new_msg_d = first_i;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    ld_idx_d = ld_idx_q + 6'd1;
                    if (ld_idx_q == 6'd63) begin
                        state_d = new_msg_q ? ST_CLR : ST_COMP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CLR: begin
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = ST_COMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_COMP: begin
                if (cnt_q == COMP_LAST) begin
                    state_d = ST_UPD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_UPD: begin
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state that produces them, so
    // clr_o, w_o/k_o and update_o form one contiguous, gap-free stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ld_idx_q  <= '0;
            new_msg_q <= 1'b0;
            ready_q   <= 1'b0;
            clr_q     <= 1'b0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_idx_q  <= ld_idx_d;
            new_msg_q <= new_msg_d;
            ready_q   <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            clr_q     <= (state_q == ST_CLR);
            upd_q     <= (state_q == ST_UPD);
            busy_q    <= (state_q != ST_IDLE);
            done_q    <= (state_q == ST_DONE);
            w_q       <= word_act ? w_cur : '0;
        end
    end

    // Message storage is pure datapath; its contents are only trusted after a full load.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            msg_q[ld_idx_q[5:4]][ld_idx_q[3:0]] <= data_i;
        end else if (expand) begin
            msg_q[lane][idx_m16] <= w_exp;
        end
    end

    sha256_k_rom u_k_rom (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (word_act),
        .addr_i (rnd),
        .k_o    (k_o)
    );

`ifdef SHA256_SCHED_BLK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`else
    assign blk_cnt_o = '0;
`endif

    assign ready_o  = ready_q;
    assign w_o      = w_q;
    assign clr_o    = clr_q;
    assign update_o = upd_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: reference message expansion feeds an expected queue,
// plus vector tables for the "abc" block and lane interleave.
module tb_sha256_msg_sched;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int          c;
        logic [31:0] w;
        logic [31:0] k;
        bit          chk_w;
    } vec_t;

    logic        clk;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        first_i;
    logic        ready_o;
    logic [31:0] w_o;
    logic [31:0] k_o;
    logic        clr_o;
    logic        update_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] blk_cnt_o;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];
    logic [31:0] blk [4][16];
    logic [31:0] cap_w [256];
    logic [31:0] cap_k [256];
    logic [15:0] exp_blk;
    vec_t        abc_tab [24];
    vec_t        lane_tab [4];

    int          abc_r  [6] = '{0, 16, 17, 18, 19, 63};
    logic [31:0] abc_w  [6] = '{32'h61626380, 32'h61626380, 32'h000f0000,
                                32'h7da86405, 32'h600003c6, 32'h00000000};
    logic [31:0] abc_k  [6] = '{32'h428a2f98, 32'he49b69c1, 32'hefbe4786,
                                32'h0fc19dc6, 32'h240ca1cc, 32'hc67178f2};

    sha256_msg_sched dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .first_i   (first_i),
        .ready_o   (ready_o),
        .w_o       (w_o),
        .k_o       (k_o),
        .clr_o     (clr_o),
        .update_o  (update_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .blk_cnt_o (blk_cnt_o)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference expansion on a flat W[0..63] per lane; expected stream is lane-interleaved.
    task automatic push_expected();
        logic [31:0] wm [4][64];
        for (int l = 0; l < 4; l++) begin
            for (int t = 0; t < 16; t++) wm[l][t] = blk[l][t];
            for (int t = 16; t < 64; t++)
                wm[l][t] = ref_s1(wm[l][t-2]) + wm[l][t-7] + ref_s0(wm[l][t-15]) + wm[l][t-16];
        end
        for (int c = 0; c < 256; c++) exp_q.push_back({wm[c % 4][c / 4], K_TB[c / 4]});
    endtask

    task automatic fill_random();
        for (int l = 0; l < 4; l++)
            for (int t = 0; t < 16; t++) blk[l][t] = $urandom();
    endtask

    // Driver: presents words in load order; a word advances only when it was accepted.
    task automatic load_block(input bit first, input int stall_pct, input bit first_noise);
        int n = 0;
        int guard = 0;
        push_expected();
        while (n < 64 && guard < 5000) begin
            @(negedge clk);
            valid_i = ($urandom_range(0, 99) >= stall_pct);
            data_i  = blk[n / 16][n % 16];
            first_i = (n == 0) ? first : (first_noise ? 1'($urandom_range(0, 1)) : 1'b0);
            if (valid_i && ready_o) n++;
            guard++;
            @(posedge clk);
        end
        chk("load_words_accepted", n, 64);
    endtask

    task automatic wait_start(output int clr_seen, output bit ok);
        int guard = 0;
        clr_seen = 0;
        @(negedge clk);
        valid_i = 1'b0;
        first_i = 1'b0;
        while (k_o !== K_TB[0] && guard < 40) begin
            if (clr_o) clr_seen++;
            guard++;
            @(negedge clk);
        end
        ok = (guard < 40);
        chk("pass_start_seen", 32'(ok), 1);
    endtask

    // Scoreboard for one full pass: 256 words, 4 update cycles, one done pulse.
    task automatic check_pass(input bit exp_clr, input bit junk);
        int          clr_seen;
        bit          ok;
        logic [63:0] e;
        wait_start(clr_seen, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        chk("clr_cycles", clr_seen, exp_clr ? 4 : 0);
        for (int c = 0; c < 256; c++) begin
            if (c > 0) @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("exp_queue_underflow", 1, 0);
                break;
            end
            e = exp_q.pop_front();
            cap_w[c] = w_o;
            cap_k[c] = k_o;
            chk($sformatf("w c=%0d", c), w_o, e[63:32]);
            chk($sformatf("k c=%0d", c), k_o, e[31:0]);
            chk($sformatf("ctrl_quiet c=%0d", c), {28'd0, ready_o, clr_o, update_o, done_o}, 0);
            if (junk) begin
                valid_i = 1'($urandom_range(0, 1));
                data_i  = $urandom();
                first_i = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            chk($sformatf("update u=%0d", i), {30'd0, update_o, clr_o}, 32'd2);
            chk($sformatf("upd_wk_zero u=%0d", i), w_o | k_o, 0);
        end
        @(negedge clk);
        exp_blk = exp_blk + 16'd1;
        chk("done_pulse", {30'd0, done_o, update_o}, 32'd2);
`ifdef SHA256_SCHED_BLK_CNT_EN
        chk("blk_cnt", 32'(blk_cnt_o), 32'(exp_blk));
`else
        chk("blk_cnt_tied_zero", 32'(blk_cnt_o), 0);
`endif
        @(negedge clk);
        chk("after_done", {29'd0, done_o, busy_o, ready_o}, 32'd1);
    endtask

    initial begin
        int  clr_seen;
        bit  ok;
        int  k;
        bit  seen;

        n_checks = 0;
        n_fail   = 0;
        exp_blk  = '0;
        k = 0;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 6; j++) begin
                abc_tab[k] = '{c: abc_r[j] * 4 + l, w: abc_w[j], k: abc_k[j], chk_w: (abc_r[j] != 63)};
                k++;
            end
            lane_tab[l] = '{c: l, w: 32'(l * 16), k: K_TB[0], chk_w: 1'b1};
        end

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        first_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_w", w_o, 0);
        chk("rst_k", k_o, 0);
        chk("rst_ctrl", {28'd0, clr_o, update_o, busy_o, done_o}, 0);
        chk("rst_blk_cnt", 32'(blk_cnt_o), 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(ready_o), 1);

        // "abc" padded block on every lane, new message
        for (int l = 0; l < 4; l++) begin
            for (int t = 0; t < 16; t++) blk[l][t] = 32'h0;
            blk[l][0]  = 32'h61626380;
            blk[l][15] = 32'h00000018;
        end
        load_block(1'b1, 0, 1'b0);
        check_pass(1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (abc_tab[i].chk_w) chk($sformatf("abc_tab w c=%0d", abc_tab[i].c), cap_w[abc_tab[i].c], abc_tab[i].w);
            chk($sformatf("abc_tab k c=%0d", abc_tab[i].c), cap_k[abc_tab[i].c], abc_tab[i].k);
        end

        // Distinct per-lane words: lane-interleave order
        for (int l = 0; l < 4; l++)
            for (int t = 0; t < 16; t++) blk[l][t] = 32'(l * 16 + t);
        load_block(1'b1, 0, 1'b0);
        check_pass(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lane_tab w c=%0d", lane_tab[i].c), cap_w[lane_tab[i].c], lane_tab[i].w);

        // Continuation block: no clear
        fill_random();
        load_block(1'b0, 0, 1'b0);
        check_pass(1'b0, 1'b0);

        // Random stalls, first_i noise past index 0, valid_i junk during the pass
        fill_random();
        load_block(1'b0, 50, 1'b1);
        check_pass(1'b0, 1'b1);

        // Reset at c=100 aborts the pass
        fill_random();
        load_block(1'b1, 0, 1'b0);
        wait_start(clr_seen, ok);
        if (ok) begin
            repeat (100) @(negedge clk);
            rst_i = 1'b1;
            @(negedge clk);
            chk("abort_outputs_zero", w_o | k_o | {26'd0, ready_o, clr_o, update_o, busy_o, done_o, 1'b0}, 0);
            rst_i = 1'b0;
            exp_q.delete();
            @(negedge clk);
            chk("abort_idle", {30'd0, busy_o, ready_o}, 32'd1);
            seen = 1'b0;
            repeat (300) begin
                @(negedge clk);
                seen = seen | update_o | done_o | clr_o | (k_o != 0);
            end
            chk("abort_quiet", 32'(seen), 0);
        end
        exp_q.delete();
        exp_blk = '0;

        // Scheduler still works after the abort
        fill_random();
        load_block(1'b1, 20, 1'b0);
        check_pass(1'b1, 1'b0);

`ifdef SHA256_SCHED_BLK_CNT_EN
        @(negedge clk);
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        exp_blk = 16'hFFFF;
        fill_random();
        load_block(1'b0, 0, 1'b0);
        check_pass(1'b0, 1'b0);
        chk("blk_cnt_wrap", 32'(blk_cnt_o), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
